// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and the single-bit CRC16 update used by
// the transport-block CRC attachment controller.
package crc_pkg;

    localparam int              CRC_W      = 16;
    localparam int              IDX_W      = $clog2(CRC_W);
    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } crc_state_t;

    // MSB-first Galois step: feedback is the incoming bit xor the register MSB.
    function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] s, input logic d);
        logic fb;
        fb = d ^ s[CRC_W-1];
        return {s[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
    endfunction

endpackage

// File: rtl/crc_attach_ctrl_if.sv
// Serial bit stream with valid/ready handshake; used for both the TB input
// stream and the data+parity output stream.
interface crc_attach_ctrl_if;

    logic dat;
    logic valid;
    logic ready;

    modport master (output dat, output valid, input ready);
    modport slave  (input dat, input valid, output ready);

endinterface

// File: rtl/crc16_serial.sv
// gCRC16 LFSR: seeded load, data update (feedback) and plain left shift used
// to stream the parity bits out MSB-first.
module crc16_serial
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] SEED = 16'h0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             SHIFT_IN,
    input  logic             DIN,
    input  logic             SHIFT_OUT,
    output logic [CRC_W-1:0] STATE
);

    logic [CRC_W-1:0] state_reg;

    always_ff @(posedge CLK) begin
        if (RST || LOAD) begin
            state_reg <= SEED;
        end else if (SHIFT_IN) begin
            state_reg <= crc16_step(state_reg, DIN);
        end else if (SHIFT_OUT) begin
            state_reg <= {state_reg[CRC_W-2:0], 1'b0};
        end
    end

    assign STATE = state_reg;

endmodule

// File: rtl/crc_attach_ctrl.sv
// Forwards one transport block bit-serially while accumulating gCRC16, then
// appends the 16 parity bits on the same backpressured output stream.
module crc_attach_ctrl
    import crc_pkg::*;
#(
    parameter int               LEN_W = 16,
    parameter logic [CRC_W-1:0] SEED  = 16'h0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                TB_START,
    input  logic [LEN_W-1:0]    TB_LEN,
    crc_attach_ctrl_if.slave    in_stream,
    crc_attach_ctrl_if.master   out_stream,
    output logic                OUT_LAST,
    output logic [CRC_W-1:0]    CRC_WORD,
    output logic                CRC_DONE,
    output logic                BUSY,
    output logic                ERR_LEN
);

    crc_state_t       state_reg, state_next;
    logic [LEN_W-1:0] count_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CRC_W-1:0] crc_cap_reg;
    logic [CRC_W-1:0] crc_word_reg;
    logic [CRC_W-1:0] lfsr_state;
    logic             out_bit_reg, out_valid_reg, out_last_reg;
    logic             crc_done_reg, err_len_reg;

    logic slot_free, in_ready, accept, crc_load, lfsr_load, start_err;
    logic last_data, last_crc;

    assign slot_free = !out_valid_reg || out_stream.ready;
    assign last_data = (count_reg == LEN_W'(1));
    assign last_crc  = (idx_reg == '0);

    crc16_serial #(.SEED(SEED)) u_lfsr (
        .CLK       (CLK),
        .RST       (RST),
        .LOAD      (lfsr_load),
        .SHIFT_IN  (accept),
        .DIN       (in_stream.dat),
        .SHIFT_OUT (crc_load),
        .STATE     (lfsr_state)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (lfsr_load)             state_next = DATA;
            DATA:    if (accept && last_data)   state_next = CRC;
            CRC:     if (crc_load && last_crc)  state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        accept    = 1'b0;
        crc_load  = 1'b0;
        lfsr_load = 1'b0;
        start_err = 1'b0;
        case (state_reg)
            IDLE: begin
                lfsr_load = TB_START && (TB_LEN != '0);
                start_err = TB_START && (TB_LEN == '0);
            end
            DATA: begin
                in_ready = slot_free;
                accept   = slot_free && in_stream.valid;
            end
            CRC:     crc_load = slot_free;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg     <= '0;
            idx_reg       <= '0;
            crc_cap_reg   <= '0;
            crc_word_reg  <= '0;
            out_bit_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            crc_done_reg  <= 1'b0;
            err_len_reg   <= 1'b0;
        end else begin
            crc_done_reg <= 1'b0;
            err_len_reg  <= start_err;

            if (lfsr_load) begin
                count_reg <= TB_LEN;
            end else if (accept) begin
                count_reg <= count_reg - 1'b1;
            end

            if (accept && last_data) begin
                idx_reg <= IDX_W'(CRC_W - 1);
            end else if (crc_load) begin
                idx_reg <= idx_reg - 1'b1;
            end

            // The LFSR is still unshifted while the first parity bit is pending.
            if (state_reg == CRC && idx_reg == IDX_W'(CRC_W - 1)) begin
                crc_cap_reg <= lfsr_state;
            end

            if (accept) begin
                out_bit_reg   <= in_stream.dat;
                out_valid_reg <= 1'b1;
                out_last_reg  <= 1'b0;
            end else if (crc_load) begin
                out_bit_reg   <= lfsr_state[CRC_W-1];
                out_valid_reg <= 1'b1;
                out_last_reg  <= last_crc;
                if (last_crc) begin
                    crc_word_reg <= crc_cap_reg;
                    crc_done_reg <= 1'b1;
                end
            end else if (out_stream.ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign in_stream.ready  = in_ready;
    assign out_stream.dat   = out_bit_reg;
    assign out_stream.valid = out_valid_reg;
    assign OUT_LAST         = out_last_reg;
    assign CRC_WORD         = crc_word_reg;
    assign CRC_DONE         = crc_done_reg;
    assign BUSY             = (state_reg != IDLE);
    assign ERR_LEN          = err_len_reg;

endmodule

// File: tb/tb_crc_attach_ctrl.sv
// Directed and randomized checks of crc_attach_ctrl against a polynomial
// long-division CRC model and an expected-bit-stream scoreboard.
module tb_crc_attach_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        TB_START = 1'b0;
    logic [15:0] TB_LEN = '0;
    logic        OUT_LAST;
    logic [15:0] CRC_WORD;
    logic        CRC_DONE, BUSY, ERR_LEN;

    crc_attach_ctrl_if in_if ();
    crc_attach_ctrl_if out_if ();

    crc_attach_ctrl #(.LEN_W(16), .SEED(16'h0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TB_START   (TB_START),
        .TB_LEN     (TB_LEN),
        .in_stream  (in_if),
        .out_stream (out_if),
        .OUT_LAST   (OUT_LAST),
        .CRC_WORD   (CRC_WORD),
        .CRC_DONE   (CRC_DONE),
        .BUSY       (BUSY),
        .ERR_LEN    (ERR_LEN)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit msg_q[$];
    bit got_q[$];
    bit last_q[$];
    int done_cnt, err_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of msg(x)*x^16 mod g(x), by textbook long division.
    function automatic logic [15:0] ref_crc();
        bit r[$];
        logic [16:0] g;
        logic [15:0] res;
        g = 17'h11021;
        r = msg_q;
        repeat (16) r.push_back(1'b0);
        for (int i = 0; i < msg_q.size(); i++)
            if (r[i])
                for (int k = 0; k <= 16; k++) r[i+k] = r[i+k] ^ g[16-k];
        for (int k = 0; k < 16; k++) res[15-k] = r[msg_q.size()+k];
        return res;
    endfunction

    task automatic load_ascii();
        string s;
        byte   c;
        s = "123456789";
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            for (int b = 7; b >= 0; b--) msg_q.push_back(c[b]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " OUT_VALID"}, out_if.valid, 1'b0);
        chk({tag, " OUT_BIT"}, out_if.dat, 1'b0);
        chk({tag, " OUT_LAST"}, OUT_LAST, 1'b0);
        chk({tag, " CRC_WORD"}, CRC_WORD, 16'h0000);
        chk({tag, " CRC_DONE"}, CRC_DONE, 1'b0);
        chk({tag, " ERR_LEN"}, ERR_LEN, 1'b0);
        chk({tag, " BUSY"}, BUSY, 1'b0);
        chk({tag, " IN_READY"}, in_if.ready, 1'b0);
    endtask

    // Runs one block from msg_q; stall randomizes both handshakes.
    // mid_start>=0 pulses TB_START at that cycle; rst_at>0 aborts after that many output bits.
    task automatic run_block(input string name, input int stall, input int mid_start, input int rst_at);
        int len, in_idx, budget;
        bit prev_stall, prev_bit, aborted;
        logic [15:0] exp_crc;
        bit exp_q[$];
        len = msg_q.size();
        budget = 8 * (len + 16) + 40;
        @(posedge CLK); #1;
        TB_START = 1'b1; TB_LEN = 16'(len);
        @(posedge CLK); #1;
        TB_START = 1'b0;
        in_idx = 0; done_cnt = 0; err_seen = 0; prev_stall = 0; prev_bit = 0; aborted = 0;
        got_q.delete(); last_q.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            in_if.valid = (in_idx < len) && (stall != 0 ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (in_idx < len) in_if.dat = msg_q[in_idx];
            out_if.ready = (stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            TB_START = (cyc == mid_start);
            if (cyc == mid_start) TB_LEN = 16'd5;
            @(negedge CLK);
            if (prev_stall) begin
                chk({name, " stall valid"}, out_if.valid, 1'b1);
                chk({name, " stall bit"}, out_if.dat, prev_bit);
            end
            if (CRC_DONE) done_cnt++;
            if (ERR_LEN) err_seen++;
            if (in_if.ready && in_if.valid) in_idx++;
            prev_stall = out_if.valid && !out_if.ready;
            prev_bit = out_if.dat;
            if (out_if.valid && out_if.ready) begin
                got_q.push_back(out_if.dat);
                last_q.push_back(OUT_LAST);
            end
            @(posedge CLK); #1;
            TB_START = 1'b0;
            if (rst_at > 0 && got_q.size() == rst_at) begin
                aborted = 1;
                break;
            end
            if (got_q.size() == len + 16) break;
        end
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        if (aborted) begin
            RST = 1'b1;
            @(posedge CLK); #1;
            check_reset_outputs({name, " abort"});
            chk({name, " abort no CRC_DONE"}, done_cnt, 0);
            RST = 1'b0;
        end else begin
            exp_crc = ref_crc();
            exp_q = msg_q;
            for (int k = 15; k >= 0; k--) exp_q.push_back(exp_crc[k]);
            chk({name, " bit count"}, got_q.size(), len + 16);
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                chk($sformatf("%s bit%0d", name, i), got_q[i], exp_q[i]);
                chk($sformatf("%s last%0d", name, i), last_q[i], (i == len + 15));
            end
            chk({name, " CRC_WORD"}, CRC_WORD, exp_crc);
            chk({name, " CRC_DONE count"}, done_cnt, 1);
            chk({name, " no ERR_LEN"}, err_seen, 0);
        end
        TB_LEN = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.valid = 1'b0;
        in_if.dat = 1'b0;
        out_if.ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;
        out_if.ready = 1'b1;

        load_ascii();
        run_block("ascii", 0, -1, 0);
        chk("ascii CRC 31C3", CRC_WORD, 16'h31C3);

        msg_q.delete(); msg_q.push_back(1'b1);
        run_block("len1", 0, -1, 0);
        chk("len1 CRC 1021", CRC_WORD, 16'h1021);

        msg_q.delete(); repeat (16) msg_q.push_back(1'b0);
        run_block("zeros16", 0, -1, 0);
        chk("zeros16 CRC 0000", CRC_WORD, 16'h0000);

        @(posedge CLK); #1;
        TB_START = 1'b1; TB_LEN = 16'd0;
        @(posedge CLK); #1;
        TB_START = 1'b0;
        chk("len0 ERR_LEN", ERR_LEN, 1'b1);
        chk("len0 BUSY", BUSY, 1'b0);
        chk("len0 OUT_VALID", out_if.valid, 1'b0);
        @(posedge CLK); #1;
        chk("len0 ERR_LEN drop", ERR_LEN, 1'b0);
        chk("len0 BUSY later", BUSY, 1'b0);
        chk("len0 OUT_VALID later", out_if.valid, 1'b0);

        load_ascii();
        run_block("ascii stall", 1, -1, 0);
        load_ascii();
        run_block("ascii midstart", 1, 30, 0);
        chk("midstart CRC 31C3", CRC_WORD, 16'h31C3);
        load_ascii();
        run_block("ascii rst40", 0, -1, 40);
        msg_q.delete(); msg_q.push_back(1'b1);
        run_block("post-rst len1", 0, -1, 0);

        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, 200);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom_range(0, 1)));
            run_block($sformatf("rand%0d", t), t % 2, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
